// File: rtl/cache_fill_controller.sv
// Miss-handling fill engine: picks a pending I- or D-cache miss (D first), streams one
// block from pipelined main memory into the target data array, then commits the tag.
module cache_fill_controller #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int IDX_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              fill_target,
    output logic              fill_word_wen,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_tag_wen,
    output logic [ADDR_W-1:0] fill_tag_addr,
    output logic              fill_done,
    busy
);

    // Handshake: mem_req issues one read per cycle with no back-pressure; memory answers
    // each read, in order and after any latency, with exactly one mem_data_valid cycle.

    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W:0]    issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic [ADDR_W-1:0] base;
    logic              target;
    logic              issuing;
    logic              word_in;
    logic              last_word;

    always_comb begin
        issuing   = (state == FILL) && (issue_cnt < (IDX_W+1)'(WORDS_PER_BLOCK));
        word_in   = (state == FILL) && mem_data_valid;
        last_word = word_in && (recv_cnt == IDX_W'(WORDS_PER_BLOCK - 1));

        state_nxt = state;
        case (state)
            IDLE:    if (d_miss || i_miss) state_nxt = FILL;
            FILL:    if (last_word) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        mem_req       = issuing;
        mem_addr      = '0;
        fill_target   = 1'b0;
        fill_word_wen = word_in;
        fill_word_idx = recv_cnt;
        fill_data     = '0;
        fill_tag_wen  = 1'b0;
        fill_tag_addr = '0;
        fill_done     = 1'b0;
        busy          = (state != IDLE);

        // base has its offset bits cleared, so this sum never leaves the block
        if (issuing) mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
        if (busy) fill_target = target;
        if (word_in) fill_data = mem_data;
        if (state == DONE) begin
            fill_tag_wen  = 1'b1;
            fill_done     = 1'b1;
            fill_tag_addr = base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
            target    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    if (d_miss) begin
                        target <= 1'b1;
                        base   <= d_miss_addr & BLOCK_MASK;
                    end else if (i_miss) begin
                        target <= 1'b0;
                        base   <= i_miss_addr & BLOCK_MASK;
                    end
                end
                FILL: begin
                    if (issuing) issue_cnt <= issue_cnt + (IDX_W+1)'(1);
                    if (word_in) recv_cnt <= recv_cnt + IDX_W'(1);
                end
                default: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: fixed-latency memory model, scoreboard of expected
// requests/words/tag commits, and per-scenario cycle-accurate strobe checks.
module tb_cache_fill_controller;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WPB    = 8;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              fill_target;
    logic              fill_word_wen;
    logic [IDX_W-1:0]  fill_word_idx;
    logic [DATA_W-1:0] fill_data;
    logic              fill_tag_wen;
    logic [ADDR_W-1:0] fill_tag_addr;
    logic              fill_done;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    logic [ADDR_W-1:0]       exp_addr_q[$];
    logic [IDX_W+DATA_W-1:0] exp_word_q[$];
    logic [ADDR_W:0]         exp_tag_q[$];

    logic req_log[64];
    logic wen_log[64];
    logic done_log[64];
    logic busy_log[64];
    logic tgt_log[64];

    cache_fill_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLOCK(WPB), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .fill_target(fill_target),
        .fill_word_wen(fill_word_wen), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
        .fill_tag_wen(fill_tag_wen), .fill_tag_addr(fill_tag_addr),
        .fill_done(fill_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory model: data 4 cycles after each request ----------------
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
    endfunction

    logic [3:0]        pv;
    logic [DATA_W-1:0] pd[4];
    logic              inj_valid;

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < 4; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[2:0], mem_req};
            pd[0] <= mem_word(mem_addr);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
        end
    end

    assign mem_data_valid = pv[3] | inj_valid;
    assign mem_data       = inj_valid ? 16'hDEAD : pd[3];

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_req: unexpected mem_req addr=%h", mem_addr);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = exp_addr_q.pop_front();
                    if (mem_addr !== e) begin
                        errors++;
                        $display("FAIL sb_addr: got %h want %h", mem_addr, e);
                    end
                end
            end
            if (fill_word_wen) begin
                vectors++;
                if (exp_word_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_word: unexpected write idx=%0d data=%h", fill_word_idx, fill_data);
                end else begin
                    logic [IDX_W+DATA_W-1:0] e;
                    e = exp_word_q.pop_front();
                    if ({fill_word_idx, fill_data} !== e) begin
                        errors++;
                        $display("FAIL sb_word: got idx=%0d data=%h want idx=%0d data=%h",
                                 fill_word_idx, fill_data, e[IDX_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            if (fill_tag_wen) begin
                vectors++;
                if (exp_tag_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_tag: unexpected tag write addr=%h", fill_tag_addr);
                end else begin
                    logic [ADDR_W:0] e;
                    e = exp_tag_q.pop_front();
                    if ({fill_target, fill_tag_addr} !== e) begin
                        errors++;
                        $display("FAIL sb_tag: got tgt=%b addr=%h want tgt=%b addr=%h",
                                 fill_target, fill_tag_addr, e[ADDR_W], e[ADDR_W-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_fill(input logic tgt, input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] b;
        b = addr & 16'hFFF0;
        for (int i = 0; i < WPB; i++) begin
            exp_addr_q.push_back(b + 16'(2 * i));
            exp_word_q.push_back({IDX_W'(i), mem_word(b + 16'(2 * i))});
        end
        exp_tag_q.push_back({tgt, b});
    endtask

    // Records strobes for cycles 1..n after the current negedge (cycle 0).
    task automatic observe(input int n, input int drop_d, input int drop_i);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            req_log[k]  = mem_req;
            wen_log[k]  = fill_word_wen;
            done_log[k] = fill_done;
            busy_log[k] = busy;
            tgt_log[k]  = fill_target;
            if (k == drop_d) d_miss = 1'b0;
            if (k == drop_i) i_miss = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; i_miss = 0; d_miss = 0; i_miss_addr = '0; d_miss_addr = '0; inj_valid = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, fill_target, fill_word_wen, fill_word_idx, fill_data,
             fill_tag_wen, fill_tag_addr, fill_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h busy=%b tagw=%b, want all 0",
                     mem_req, mem_addr, busy, fill_tag_wen);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_d_fill();
        d_miss = 1'b1; d_miss_addr = 16'h1234;
        push_fill(1'b1, 16'h1234);
        observe(14, 13, 0);
        for (int k = 1; k <= 14; k++) begin
            vectors++;
            if (req_log[k] !== (k <= 8) || wen_log[k] !== (k >= 5 && k <= 12) ||
                done_log[k] !== (k == 13) || busy_log[k] !== (k <= 13)) begin
                errors++;
                $display("FAIL d_fill_timing c%0d: req=%b wen=%b done=%b busy=%b want %b %b %b %b",
                         k, req_log[k], wen_log[k], done_log[k], busy_log[k],
                         k <= 8, k >= 5 && k <= 12, k == 13, k <= 13);
            end
        end
        vectors++;
        if (tgt_log[13] !== 1'b1) begin
            errors++;
            $display("FAIL d_fill_target: got %b want 1", tgt_log[13]);
        end
    endtask

    task automatic test_priority();
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h2000;
        push_fill(1'b1, 16'h2000);
        push_fill(1'b0, 16'h0040);
        observe(28, 1, 15);
        vectors++;
        if (done_log[13] !== 1'b1 || tgt_log[13] !== 1'b1) begin
            errors++;
            $display("FAIL prio_d_done: done=%b tgt=%b want 1 1", done_log[13], tgt_log[13]);
        end
        vectors++;
        if (busy_log[14] !== 1'b0 || req_log[14] !== 1'b0 || req_log[15] !== 1'b1) begin
            errors++;
            $display("FAIL prio_i_start: busy14=%b req14=%b req15=%b want 0 0 1",
                     busy_log[14], req_log[14], req_log[15]);
        end
        vectors++;
        if (done_log[27] !== 1'b1 || tgt_log[27] !== 1'b0 || busy_log[28] !== 1'b0) begin
            errors++;
            $display("FAIL prio_i_done: done27=%b tgt27=%b busy28=%b want 1 0 0",
                     done_log[27], tgt_log[27], busy_log[28]);
        end
    endtask

    task automatic test_top_block();
        int nreq;
        i_miss = 1'b1; i_miss_addr = 16'hFFFE;
        push_fill(1'b0, 16'hFFFE);
        observe(16, 0, 1);
        nreq = 0;
        for (int k = 1; k <= 16; k++) nreq += int'(req_log[k]);
        vectors++;
        if (nreq !== 8 || done_log[13] !== 1'b1) begin
            errors++;
            $display("FAIL top_block: requests=%0d done13=%b want 8 1", nreq, done_log[13]);
        end
    endtask

    task automatic test_reset_mid_fill();
        i_miss = 1'b1; i_miss_addr = 16'h0100;
        push_fill(1'b0, 16'h0100);
        observe(6, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, fill_target, fill_word_wen, fill_word_idx, fill_data,
             fill_tag_wen, fill_tag_addr, fill_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: req=%b addr=%h wen=%b idx=%0d tagw=%b busy=%b want all 0",
                     mem_req, mem_addr, fill_word_wen, fill_word_idx, fill_tag_wen, busy);
        end
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_tag_q.delete();
        rst = 1'b0;
        i_miss = 1'b1;
        push_fill(1'b0, 16'h0100);
        observe(14, 0, 1);
        vectors++;
        if (req_log[1] !== 1'b1 || wen_log[5] !== 1'b1 || wen_log[4] !== 1'b0 ||
            done_log[13] !== 1'b1 || busy_log[14] !== 1'b0) begin
            errors++;
            $display("FAIL restart_fill: req1=%b wen4=%b wen5=%b done13=%b busy14=%b want 1 0 1 1 0",
                     req_log[1], wen_log[4], wen_log[5], done_log[13], busy_log[14]);
        end
    endtask

    task automatic test_idle_valid();
        int n;
        n = $urandom_range(2, 5);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            inj_valid = 1'b1;
            #1;
            vectors++;
            if (fill_word_wen !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: wen=%b busy=%b want 0 0", fill_word_wen, busy);
            end
        end
        @(negedge clk);
        inj_valid = 1'b0;
    endtask

    task automatic test_miss_drop();
        int nwen;
        i_miss = 1'b1; i_miss_addr = 16'h0A5C;
        push_fill(1'b0, 16'h0A5C);
        observe(14, 0, 3);
        nwen = 0;
        for (int k = 1; k <= 14; k++) nwen += int'(wen_log[k]);
        vectors++;
        if (nwen !== 8 || done_log[13] !== 1'b1 || busy_log[14] !== 1'b0) begin
            errors++;
            $display("FAIL miss_drop: writes=%0d done13=%b busy14=%b want 8 1 0",
                     nwen, done_log[13], busy_log[14]);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            logic [ADDR_W-1:0] a;
            logic              side;
            a    = 16'($urandom_range(0, 16'hFFFF));
            side = 1'($urandom_range(0, 1));
            if (side) begin d_miss = 1'b1; d_miss_addr = a; end
            else begin i_miss = 1'b1; i_miss_addr = a; end
            push_fill(side, a);
            observe(14, 1, 1);
            vectors++;
            if (done_log[13] !== 1'b1 || tgt_log[13] !== side) begin
                errors++;
                $display("FAIL b2b_done r%0d: done=%b tgt=%b want 1 %b", r, done_log[13], tgt_log[13], side);
            end
        end
    endtask

    initial begin
        test_reset();
        test_d_fill();
        test_priority();
        test_top_block();
        test_reset_mid_fill();
        test_idle_valid();
        test_miss_drop();
        test_back_to_back();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_addr_q.size() != 0 || exp_word_q.size() != 0 || exp_tag_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: left addr=%0d word=%0d tag=%0d want 0 0 0",
                     exp_addr_q.size(), exp_word_q.size(), exp_tag_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
